// File: rtl/rng_sample_sched.sv
// D-RaNGe sampling scheduler: issues periodic reduced-tRCD reads and packs selected line bits
// into 32-bit random words. Define RNG_SCHED_STATS_EN to build the sample/stall counters.
module rng_sample_sched #(
  parameter int unsigned ADDR_W     = 28,
  parameter int unsigned LINE_W     = 512,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [31:0]       rng_prd,
  input  logic [ADDR_W-1:0] rng_addr,
  input  logic [8:0]        rng_idx1,
  input  logic [8:0]        rng_idx2,
  input  logic [8:0]        rng_idx3,
  input  logic [8:0]        rng_idx4,
  input  logic              rng_boost_enable,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic              req_lowtrcd,
  input  logic              rsp_valid,
  input  logic [LINE_W-1:0] rsp_data,
  output logic              rnd_valid,
  output logic [31:0]       rnd_data,
  input  logic              rnd_ready,
  output logic              busy,
  output logic [31:0]       stat_samples,
  output logic [31:0]       stat_full_stalls
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StWaitPrd, StIssue, StWaitRsp} state_e;

  state_e                        state_q, state_d;
  logic [31:0]                   cnt_q, cnt_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [3:0][8:0]               idx_q, idx_d;
  logic [31:0]                   shift_q, shift_d;
  logic [2:0]                    nib_cnt_q, nib_cnt_d;
  logic [PtrW:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH-1:0][31:0]   mem_q, mem_d;

  logic [31:0] prd_m1;
  logic        prd_met;
  logic [3:0]  nibble;
  logic [31:0] word;
  logic        push, pop, fifo_full, fifo_empty, rsp_take;

  // Out-of-range indices never match any line position and read as 0.
  function automatic logic pick_bit(input logic [LINE_W-1:0] line, input logic [8:0] idx);
    logic b;
    b = 1'b0;
    for (int unsigned i = 0; i < LINE_W; i++) begin
      if (32'(idx) == i) b = line[i];
    end
    return b;
  endfunction

  assign prd_m1  = (rng_prd == 32'd0) ? 32'd0 : rng_prd - 32'd1;
  assign prd_met = rng_boost_enable || (cnt_q >= prd_m1);

  assign nibble = {pick_bit(rsp_data, idx_q[3]), pick_bit(rsp_data, idx_q[2]),
                   pick_bit(rsp_data, idx_q[1]), pick_bit(rsp_data, idx_q[0])};
  assign word   = {shift_q[27:0], nibble};

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign pop        = rnd_ready && !fifo_empty;
  assign rsp_take   = (state_q == StWaitRsp) && rsp_valid;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    nib_cnt_d = nib_cnt_q;
    push      = 1'b0;
    req_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StWaitPrd;
          cnt_d   = '0;
        end
      end
      StWaitPrd: begin
        if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
        if (!enable) begin
          state_d = StIdle;
        end else if (prd_met && !fifo_full) begin
          state_d = StIssue;
          addr_d  = rng_addr;
        end
      end
      StIssue: begin
        // Held until accepted, regardless of enable.
        req_valid = 1'b1;
        if (req_ready) begin
          state_d = StWaitRsp;
          idx_d   = {rng_idx4, rng_idx3, rng_idx2, rng_idx1};
        end
      end
      StWaitRsp: begin
        if (rsp_valid) begin
          shift_d   = word;
          nib_cnt_d = nib_cnt_q + 3'd1;
          push      = (nib_cnt_q == 3'd7);
          cnt_d     = '0;
          state_d   = enable ? StWaitPrd : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[PtrW-1:0]] = word;
      wr_ptr_d                  = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      nib_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      nib_cnt_q <= nib_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Storage needs no reset: reads are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign req_addr    = addr_q;
  assign req_lowtrcd = req_valid;
  assign rnd_valid   = !fifo_empty;
  assign rnd_data    = fifo_empty ? 32'd0 : mem_q[rd_ptr_q[PtrW-1:0]];
  assign busy        = (state_q != StIdle);

`ifdef RNG_SCHED_STATS_EN
  logic [31:0] samples_q, samples_d, stalls_q, stalls_d;

  always_comb begin
    samples_d = samples_q;
    stalls_d  = stalls_q;
    if (rsp_take && samples_q != '1) samples_d = samples_q + 32'd1;
    if (state_q == StWaitPrd && prd_met && fifo_full && stalls_q != '1) begin
      stalls_d = stalls_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samples_q <= '0;
      stalls_q  <= '0;
    end else begin
      samples_q <= samples_d;
      stalls_q  <= stalls_d;
    end
  end

  assign stat_samples     = samples_q;
  assign stat_full_stalls = stalls_q;
`else
  logic unused_rsp_take;
  assign unused_rsp_take  = rsp_take;
  assign stat_samples     = 32'd0;
  assign stat_full_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_rng_sample_sched.sv
// Directed bench for rng_sample_sched: period spacing, bit packing, boost, FIFO-full gating,
// held request with enable drop, and reset during an outstanding read.
module tb_rng_sample_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [31:0]  rng_prd;
  logic [27:0]  rng_addr;
  logic [8:0]   rng_idx1, rng_idx2, rng_idx3, rng_idx4;
  logic         rng_boost_enable;
  logic         req_valid, req_ready, req_lowtrcd;
  logic [27:0]  req_addr;
  logic         rsp_valid;
  logic [511:0] rsp_data;
  logic         rnd_valid, rnd_ready;
  logic [31:0]  rnd_data;
  logic         busy;
  logic [31:0]  stat_samples, stat_full_stalls;

  int nchk  = 0;
  int npass = 0;
  int cyc   = 0;

  rng_sample_sched dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .rng_prd          (rng_prd),
    .rng_addr         (rng_addr),
    .rng_idx1         (rng_idx1),
    .rng_idx2         (rng_idx2),
    .rng_idx3         (rng_idx3),
    .rng_idx4         (rng_idx4),
    .rng_boost_enable (rng_boost_enable),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_lowtrcd      (req_lowtrcd),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .rnd_valid        (rnd_valid),
    .rnd_data         (rnd_data),
    .rnd_ready        (rnd_ready),
    .busy             (busy),
    .stat_samples     (stat_samples),
    .stat_full_stalls (stat_full_stalls)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [511:0] make_line(input logic [3:0] nib);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    l[0]   = nib[0];
    l[1]   = nib[1];
    l[2]   = nib[2];
    l[511] = nib[3];
    return l;
  endfunction

  task automatic get_req(input string tag, output int at);
    int n;
    n = 0;
    while (req_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    at = cyc;
    chk(tag, {31'd0, req_valid}, 32'd1);
  endtask

  // Accept in the current cycle, return the line dly cycles later; ends one cycle after rsp.
  task automatic serve(input logic [3:0] nib, input int dly, output logic rv_at_rsp);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    repeat (dly - 1) tick();
    rsp_data  = make_line(nib);
    rsp_valid = 1'b1;
    rv_at_rsp = rnd_valid;
    tick();
    rsp_valid = 1'b0;
  endtask

  initial begin
    logic [3:0]  s1 [8];
    logic [31:0] w [8];
    logic        rv;
    int          at, prev;
    logic [31:0] s_a, s_b;
    bit          quiet;

    s1 = '{4'hA, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5};
    for (int k = 0; k < 8; k++) w[k] = 32'h9E3779B9 * (k + 1);

    rst = 1'b1; enable = 1'b0; rng_prd = 32'd10; rng_addr = 28'h1234567;
    rng_idx1 = 9'd0; rng_idx2 = 9'd1; rng_idx3 = 9'd2; rng_idx4 = 9'd511;
    rng_boost_enable = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    rnd_ready = 1'b0;
    repeat (3) tick();

    chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_req_addr", {4'd0, req_addr}, 32'd0);
    chk("rst_lowtrcd", {31'd0, req_lowtrcd}, 32'd0);
    chk("rst_rnd_valid", {31'd0, rnd_valid}, 32'd0);
    chk("rst_rnd_data", rnd_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_samples", stat_samples, 32'd0);
    chk("rst_stalls", stat_full_stalls, 32'd0);
    rst = 1'b0;
    tick();

    // Period 10, rsp 3 cycles after accept: issues 10+3+1 cycles apart.
    enable = 1'b1;
    for (int t = 0; t < 8; t++) begin
      get_req("p10_req", at);
      if (t > 0) chk("p10_spacing", 32'(at - prev), 32'd14);
      chk("p10_addr", {4'd0, req_addr}, 32'h1234567);
      chk("p10_lowtrcd", {31'd0, req_lowtrcd}, 32'd1);
      prev = at;
      serve(s1[t], 3, rv);
    end
    chk("pack_valid_at_rsp", {31'd0, rv}, 32'd0);
    chk("pack_valid_after", {31'd0, rnd_valid}, 32'd1);
    chk("pack_word", rnd_data, 32'hA5555555);
    rnd_ready = 1'b1;
    tick();
    rnd_ready = 1'b0;
    chk("pack_popped", {31'd0, rnd_valid}, 32'd0);

    // Boost ignores the 1000-cycle period: one WAIT_PRD cycle between response and issue.
    rng_boost_enable = 1'b1;
    rng_prd = 32'd1000;
    for (int t = 0; t < 8; t++) begin
      get_req("boost_req", at);
      if (t > 0) chk("boost_spacing", 32'(at - prev), 32'd5);
      prev = at;
      serve(4'(t), 3, rv);
    end
    chk("boost_word", rnd_data, 32'h01234567);
    rnd_ready = 1'b1;
    tick();
    rnd_ready = 1'b0;

    // Fill all eight FIFO entries with the consumer stalled.
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) begin
        get_req("fill_req", at);
        serve(w[k][31-4*j -: 4], 3, rv);
      end
    end
    s_a = stat_full_stalls;
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (req_valid !== 1'b0 || busy !== 1'b1) quiet = 1'b0;
      tick();
    end
    s_b = stat_full_stalls;
    for (int i = 0; i < 20; i++) begin
      if (req_valid !== 1'b0) quiet = 1'b0;
      tick();
    end
    chk("full_no_req", {31'd0, quiet}, 32'd1);
`ifdef RNG_SCHED_STATS_EN
    chk("stall_start", s_a, 32'd0);
    chk("stall_incr", s_b - s_a, 32'd10);
    chk("samples", stat_samples, 32'd80);
`else
    chk("stall_tied", s_b, 32'd0);
    chk("samples_tied", stat_samples, 32'd0);
`endif
    chk("full_head", rnd_data, w[0]);
    rnd_ready = 1'b1;
    tick();
    rnd_ready = 1'b0;
    get_req("resume_req", at);
    serve(4'h1, 3, rv);
    enable = 1'b0;
    rnd_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      chk("order_valid", {31'd0, rnd_valid}, 32'd1);
      chk("order_data", rnd_data, w[k]);
      tick();
    end
    rnd_ready = 1'b0;
    chk("drained", {31'd0, rnd_valid}, 32'd0);
    chk("idle_after_drain", {31'd0, busy}, 32'd0);

    // Arbiter stall for 5 cycles; enable drops and rng_addr changes during the hold.
    rng_boost_enable = 1'b0;
    rng_prd = 32'd3;
    enable = 1'b1;
    get_req("hold_req", at);
    rng_addr = 28'h0ABCDEF;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (req_valid !== 1'b1 || req_addr !== 28'h1234567) quiet = 1'b0;
      if (i == 2) enable = 1'b0;
      tick();
    end
    chk("hold_stable", {31'd0, quiet}, 32'd1);
    chk("hold_still_valid", {31'd0, req_valid}, 32'd1);
    serve(4'h2, 3, rv);
    chk("hold_idle_busy", {31'd0, busy}, 32'd0);
    chk("hold_idle_req", {31'd0, req_valid}, 32'd0);

    // Partial word survives the enable toggle; period 3 gives 3+3+1 spacing.
    enable = 1'b1;
    for (int t = 0; t < 6; t++) begin
      get_req("p3_req", at);
      if (t > 0) chk("p3_spacing", 32'(at - prev), 32'd7);
      chk("p3_addr", {4'd0, req_addr}, 32'h0ABCDEF);
      prev = at;
      serve(4'(t + 3), 3, rv);
    end
    enable = 1'b0;
    chk("persist_valid", {31'd0, rnd_valid}, 32'd1);
    chk("persist_word", rnd_data, 32'h12345678);
    rnd_ready = 1'b1;
    tick();
    rnd_ready = 1'b0;

    // Reset while a read is outstanding; the late response must be ignored.
    enable = 1'b1;
    get_req("rst_case_req", at);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("rst_case_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    enable = 1'b0;
    tick();
    rst = 1'b0;
    rsp_data = make_line(4'hF);
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    repeat (3) tick();
    chk("post_rst_rnd_valid", {31'd0, rnd_valid}, 32'd0);
    chk("post_rst_rnd_data", rnd_data, 32'd0);
    chk("post_rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("post_rst_req_addr", {4'd0, req_addr}, 32'd0);
    chk("post_rst_lowtrcd", {31'd0, req_lowtrcd}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_samples", stat_samples, 32'd0);
    chk("post_rst_stalls", stat_full_stalls, 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
